sm_accumulator: RTL and testbench

SM_ACCUMULATOR -- requirements
Module: sm_accumulator

---
 rtl/sm_pkg.sv | 16 +
 rtl/sm_add.sv | 48 ++++
 rtl/sm_accumulator.sv | 91 +++++++++
 tb/tb_sm_accumulator.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sm_pkg.sv
// Shared definitions for the sign-magnitude accumulator.
// Widths, saturation limit and FSM state encoding.
package sm_pkg;
  localparam int DATA_W = 32;
  localparam int MAG_W  = 31;
  localparam int CNT_W  = 8;

  localparam logic [DATA_W-1:0] MAG_MAX =
    32'h7FFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;
endpackage

// File: rtl/sm_add.sv
// Combinational sign-magnitude adder with saturation.
// Ports: a_i, b_i operands; sum_o canonical sum; sat_o saturated.
module sm_add
  import sm_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] sum_o,
  output logic              sat_o
);

  logic [MAG_W-1:0]  mag_a;
  logic [MAG_W-1:0]  mag_b;
  logic              sgn_a;
  logic              sgn_b;
  logic [DATA_W-1:0] wide;
  logic [MAG_W-1:0]  mag;
  logic              sgn;

  always_comb begin
    mag_a = a_i[MAG_W-1:0];
    mag_b = b_i[MAG_W-1:0];
    // a zero magnitude is always positive
    sgn_a = a_i[DATA_W-1] & (|mag_a);
    sgn_b = b_i[DATA_W-1] & (|mag_b);
    wide  = {1'b0, mag_a} + {1'b0, mag_b};
    sat_o = 1'b0;
    mag   = '0;
    sgn   = 1'b0;
    if (sgn_a == sgn_b) begin
      sgn = sgn_a;
      if (wide[DATA_W-1]) begin
        sat_o = 1'b1;
        mag   = MAG_MAX[MAG_W-1:0];
      end else begin
        mag = wide[MAG_W-1:0];
      end
    end else if (mag_a >= mag_b) begin
      sgn = sgn_a;
      mag = mag_a - mag_b;
    end else begin
      sgn = sgn_b;
      mag = mag_b - mag_a;
    end
    sum_o = {sgn & (|mag), mag};
  end

endmodule

// File: rtl/sm_accumulator.sv
// Sign-magnitude accumulator: sums terms until in_last, holds result.
// Ports: in_* term stream, out_* result handshake, rst active-low.
module sm_accumulator
  import sm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ovf,
  output logic [CNT_W-1:0]  out_count
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              vld_q, vld_d;
  logic              rdy_q, rdy_d;

  logic [DATA_W-1:0] add_sum;
  logic              add_sat;
  logic              accept;

  sm_add u_add (
    .a_i   (acc_q),
    .b_i   (in_data),
    .sum_o (add_sum),
    .sat_o (add_sat)
  );

  assign accept = in_valid & rdy_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          acc_d   = add_sum;
          ovf_d   = ovf_q | add_sat;
          cnt_d   = cnt_q + 1'b1;
          state_d = in_last ? HOLD : ACC;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    vld_d = (state_d == HOLD);
    rdy_d = (state_d != HOLD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign out_data  = acc_q;
  assign out_ovf   = ovf_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_sm_accumulator.sv
// Self-checking bench for sm_accumulator.
// Directed cases plus random terms against an integer-sum model.
module tb_sm_accumulator;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;
  logic [7:0]  out_count;

  int checks;
  int errors;

  // model: result as a plain signed integer
  bit     pend;
  longint sum;
  bit     ovf;
  int     cnt;

  sm_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint term(
    input logic [31:0] d);
    longint m;
    m = longint'(d[30:0]);
    return d[31] ? -m : m;
  endfunction

  function automatic logic [31:0] to_sm(
    input longint s);
    logic [31:0] r;
    if (s < 0) r = {1'b1, 31'(-s)};
    else       r = {1'b0, 31'(s)};
    return r;
  endfunction

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend = 1'b0;
    sum  = 0;
    ovf  = 1'b0;
    cnt  = 0;
  endtask

  // drive one cycle, check current outputs, advance model
  task automatic cycle(
    input logic        iv,
    input logic [31:0] d,
    input logic        il,
    input logic        ordy);
    in_valid  = iv;
    in_data   = d;
    in_last   = il;
    out_ready = ordy;
    check("in_ready", 32'(in_ready), 32'(!pend));
    check("out_valid", 32'(out_valid), 32'(pend));
    if (pend) begin
      check("out_data", out_data, to_sm(sum));
      check("out_ovf", 32'(out_ovf), 32'(ovf));
      check("out_count", 32'(out_count),
            32'(cnt));
    end
    @(posedge clk);
    if (pend) begin
      if (ordy) model_reset();
    end else if (iv) begin
      sum = sum + term(d);
      if (sum > 64'sh7FFF_FFFF) begin
        sum = 64'sh7FFF_FFFF;
        ovf = 1'b1;
      end else if (sum < -64'sh7FFF_FFFF) begin
        sum = -64'sh7FFF_FFFF;
        ovf = 1'b1;
      end
      cnt = (cnt + 1) % 256;
      if (il) pend = 1'b1;
    end
    #1;
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] held;
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", out_data, 0);
    check("rst_ovf", 32'(out_ovf), 0);
    check("rst_count", 32'(out_count), 0);
    @(negedge clk);
    rst = 1'b1;

    // mixed-sign sum, first term on first edge after release
    cycle(1, 32'h0000_000F, 0, 0);
    cycle(1, 32'h8000_0010, 1, 0);
    check("r31_data", out_data, 32'h8000_0001);
    check("r31_cnt", 32'(out_count), 2);
    cycle(0, 0, 0, 1);

    // saturation, then ovf cleared for next sum
    cycle(1, 32'h7FFF_FFFF, 0, 0);
    cycle(1, 32'h0000_0001, 1, 0);
    check("r32_data", out_data, 32'h7FFF_FFFF);
    check("r32_ovf", 32'(out_ovf), 1);
    cycle(0, 0, 0, 1);
    cycle(1, 32'h0000_0005, 1, 0);
    check("r32b_data", out_data, 32'h0000_0005);
    check("r32b_ovf", 32'(out_ovf), 0);
    cycle(0, 0, 0, 1);

    // cancellation and negative zero
    cycle(1, 32'h0000_000C, 0, 0);
    cycle(1, 32'h8000_000C, 1, 0);
    check("r33_zero", out_data, 32'h0);
    cycle(0, 0, 0, 1);
    cycle(1, 32'h8000_0000, 1, 0);
    check("r33_nzero", out_data, 32'h0);
    cycle(0, 0, 0, 1);

    // hold with upstream pushing
    cycle(1, 32'h8000_0009, 1, 0);
    held = out_data;
    for (int i = 0; i < 3; i++)
      cycle(1, 32'h0000_0100 + 32'(i), 1, 0);
    check("r34_hold", out_data, held);
    check("r34_cnt", 32'(out_count), 1);
    cycle(0, 0, 0, 1);
    check("r34_rdy", 32'(in_ready), 1);

    // back-to-back singles with out_ready held
    cycle(1, 32'h0000_0003, 1, 1);
    check("r35_a", out_data, 32'h0000_0003);
    cycle(1, 32'h8000_0004, 1, 1);
    cycle(1, 32'h8000_0004, 1, 1);
    check("r35_b", out_data, 32'h8000_0004);
    check("r35_cnt", 32'(out_count), 1);
    cycle(0, 0, 0, 1);

    // in_last without in_valid ignored
    cycle(1, 32'h0000_0002, 0, 0);
    cycle(0, 32'h0000_0050, 1, 0);
    cycle(1, 32'h0000_0001, 1, 0);
    check("r24_data", out_data, 32'h0000_0003);
    cycle(0, 0, 0, 1);

    // async reset mid-sum
    cycle(1, 32'h0000_0007, 0, 1);
    cycle(1, 32'h0000_0002, 0, 1);
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    model_reset();
    check("r36_valid", 32'(out_valid), 0);
    check("r36_data", out_data, 0);
    check("r36_count", 32'(out_count), 0);
    @(negedge clk);
    rst = 1'b1;
    cycle(1, 32'h0000_0001, 1, 0);
    check("r36_post", out_data, 32'h0000_0001);
    check("r36_pcnt", 32'(out_count), 1);
    cycle(0, 0, 0, 1);

    // count wraps past 255
    for (int i = 0; i < 300; i++)
      cycle(1, 32'h0000_0001, 0, 0);
    cycle(1, 32'h0000_0001, 1, 0);
    check("wrap_cnt", 32'(out_count), 45);
    check("wrap_data", out_data, 301);
    cycle(0, 0, 0, 1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0)
        d = {1'($urandom), 31'h7FFF_F000}
            + 32'($urandom_range(0, 8191));
      else
        d = {1'($urandom),
             31'($urandom_range(0, 1000))};
      cycle(1'($urandom_range(0, 3) != 0), d,
            1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
